// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM external memory bus arbiter.
package mem_port_arbiter_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [3:0]  SEL_WORD  = 4'b1111;
  localparam int unsigned TIMER_W   = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_MEM  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } bus_cmd_t;

  // Only meaningful when at least one port is eligible; ties go to the port not granted last.
  function automatic grant_e pick_grant(input logic if_elig, input logic mem_elig,
                                        input grant_e last_grant);
    if (if_elig && mem_elig) begin
      return (last_grant == GRANT_IF) ? GRANT_MEM : GRANT_IF;
    end
    return mem_elig ? GRANT_MEM : GRANT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_timer.sv
// Access watchdog: counts cycles spent waiting for bus_ack_i and flags the last allowed cycle.
module mem_port_arbiter_bus_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count equals the number of ack-less cycles already spent, so this marks the final allowed one.
  assign expired_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between instruction fetch and the MEM-stage load/store unit.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        bus_err_o
);

  arb_state_e  state_q, state_d;
  grant_e      last_grant_q, last_grant_d;
  bus_cmd_t    bus_cmd_q, bus_cmd_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] if_data_q, if_data_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_ready_q, mem_ready_d;
  logic        bus_err_q, bus_err_d;
  logic        drop_q, drop_d;

  logic        timer_clear;
  logic        timer_inc;
  logic        timer_expired;
  logic        if_elig;
  logic        mem_elig;
  logic        grant_valid;
  grant_e      grant_sel;
  logic        if_drop_now;
  logic        access_done;

  // A port whose ready pulse is out this cycle still shows its old request; it must not be re-granted.
  assign if_elig     = if_req_i & ~if_ready_q;
  assign mem_elig    = mem_req_i & ~mem_ready_q;
  assign grant_valid = (state_q == ARB_IDLE) && (if_elig || mem_elig);
  assign grant_sel   = pick_grant(if_elig, mem_elig, last_grant_q);
  assign if_drop_now = drop_q | if_flush_i;
  assign access_done = bus_ack_i | timer_expired;

  mem_port_arbiter_bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .inc_i    (timer_inc),
    .expired_o(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d = (grant_sel == GRANT_IF) ? ARB_IF : ARB_MEM;
        end
      end
      ARB_IF, ARB_MEM: begin
        if (access_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Ack takes priority over the timeout; a flushed fetch still finishes on the bus but reports nothing.
  always_comb begin
    last_grant_d = last_grant_q;
    bus_cmd_d    = bus_cmd_q;
    bus_req_d    = bus_req_q;
    if_data_d    = if_data_q;
    mem_rdata_d  = mem_rdata_q;
    drop_d       = drop_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;
    bus_err_d    = 1'b0;
    timer_clear  = 1'b0;
    timer_inc    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          bus_req_d    = 1'b1;
          timer_clear  = 1'b1;
          last_grant_d = grant_sel;
          if (grant_sel == GRANT_IF) begin
            bus_cmd_d = '{we: 1'b0, addr: if_addr_i, wdata: ZERO_WORD, sel: SEL_WORD};
            drop_d    = if_flush_i;
          end else begin
            bus_cmd_d = '{we: mem_we_i, addr: mem_addr_i, wdata: mem_wdata_i, sel: mem_sel_i};
            drop_d    = 1'b0;
          end
        end
      end
      ARB_IF: begin
        if (access_done) begin
          bus_req_d = 1'b0;
          drop_d    = 1'b0;
          bus_err_d = ~bus_ack_i;
          if (!if_drop_now) begin
            if_ready_d = 1'b1;
            if_data_d  = bus_ack_i ? bus_rdata_i : ZERO_WORD;
          end
        end else begin
          timer_inc = 1'b1;
          drop_d    = if_drop_now;
        end
      end
      ARB_MEM: begin
        if (access_done) begin
          bus_req_d   = 1'b0;
          mem_ready_d = 1'b1;
          bus_err_d   = ~bus_ack_i;
          if (!bus_ack_i) begin
            mem_rdata_d = ZERO_WORD;
          end else if (!bus_cmd_q.we) begin
            mem_rdata_d = bus_rdata_i;
          end
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_IF;
      bus_cmd_q    <= '0;
      bus_req_q    <= 1'b0;
      if_data_q    <= ZERO_WORD;
      if_ready_q   <= 1'b0;
      mem_rdata_q  <= ZERO_WORD;
      mem_ready_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      bus_cmd_q    <= bus_cmd_d;
      bus_req_q    <= bus_req_d;
      if_data_q    <= if_data_d;
      if_ready_q   <= if_ready_d;
      mem_rdata_q  <= mem_rdata_d;
      mem_ready_q  <= mem_ready_d;
      bus_err_q    <= bus_err_d;
      drop_q       <= drop_d;
    end
  end

  assign bus_req_o      = bus_req_q;
  assign bus_we_o       = bus_cmd_q.we;
  assign bus_addr_o     = bus_cmd_q.addr;
  assign bus_wdata_o    = bus_cmd_q.wdata;
  assign bus_sel_o      = bus_cmd_q.sel;
  assign if_data_o      = if_data_q;
  assign if_ready_o     = if_ready_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign mem_ready_o    = mem_ready_q;
  assign bus_err_o      = bus_err_q;
  assign stallreq_if_o  = if_req_i & ~if_ready_q;
  assign stallreq_mem_o = mem_req_i & ~mem_ready_q;

endmodule
